// File: rtl/display_tx_queue.sv
// Purpose: queues CPU DSP-register characters and replays them to the display TX port, one strobe at a time.
// Latency: a write into an empty queue strobes the display 2 cycles after it is sampled; strobes are W+2 cycles apart.
// Backpressure: busy (FIFO full) is presented to the CPU; a write while full with no pop is dropped and overflow sticks.
module display_tx_queue #(
    parameter int DEPTH       = 16,
    parameter int ADDR_W      = 4,
    parameter int PACE_CYCLES = 238636,
    parameter int GAP_FAST    = 4,
    parameter int CNT_W       = 18
) (
    input  logic              clk14,
    input  logic              rst,
    input  logic              cpu_we,
    input  logic [7:0]        cpu_din,
    input  logic              fast,
    input  logic              flush,
    output logic              busy,
    output logic [ADDR_W:0]   level,
    output logic              overflow,
    output logic              disp_address,
    output logic              disp_enable,
    output logic              disp_w_en,
    output logic [7:0]        disp_din
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STROBE,
        S_WAIT
    } state_t;

    // WAIT counts down from length-1 to 0, so a WAIT of W cycles loads W-1.
    localparam logic [CNT_W-1:0]  PACE_LOAD = CNT_W'(PACE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  FAST_LOAD = CNT_W'(GAP_FAST - 1);
    localparam logic [ADDR_W:0]   FULL_LVL  = (ADDR_W + 1)'(DEPTH);

    logic [7:0]        r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_level;
    logic              r_overflow;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_disp_enable;
    logic              r_disp_w_en;
    logic [7:0]        r_disp_din;

    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;

    assign w_full  = (r_level == FULL_LVL);
    assign w_empty = (r_level == '0);

    // IDLE takes the head only from the registered level, so a same-cycle push into an
    // empty queue waits one edge. A pop frees a slot, letting a write at full still land.
    assign w_pop   = (r_state == S_IDLE) && !w_empty && !flush;
    assign w_push  = cpu_we && !flush && (!w_full || w_pop);
    assign w_drop  = cpu_we && !flush && w_full && !w_pop;

    // Character storage; no reset needed since the pointers define what is valid.
    always_ff @(posedge clk14) begin
        if (!rst && w_push) begin
            r_mem[r_wr_ptr] <= cpu_din;
        end
    end

    // Queue pointers, occupancy and the sticky drop flag (flush never touches overflow).
    always_ff @(posedge clk14) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else if (flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + (ADDR_W + 1)'(1);
                2'b01:   r_level <= r_level - (ADDR_W + 1)'(1);
                default: r_level <= r_level;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Output pacer: pop -> single strobe -> idle gap, so the display can re-arm between chars.
    always_ff @(posedge clk14) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_disp_enable <= 1'b0;
            r_disp_w_en   <= 1'b0;
            r_disp_din    <= 8'h00;
        end else if (flush) begin
            // Abort output; the last character stays on disp_din.
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_disp_enable <= 1'b0;
            r_disp_w_en   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_disp_enable <= 1'b0;
                    r_disp_w_en   <= 1'b0;
                    if (w_pop) begin
                        r_disp_din <= r_mem[r_rd_ptr];
                        r_state    <= S_STROBE;
                    end
                end
                S_STROBE: begin
                    r_disp_enable <= 1'b1;
                    r_disp_w_en   <= 1'b1;
                    r_cnt         <= fast ? FAST_LOAD : PACE_LOAD;
                    r_state       <= S_WAIT;
                end
                S_WAIT: begin
                    r_disp_enable <= 1'b0;
                    r_disp_w_en   <= 1'b0;
                    if (r_cnt == '0) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    r_state       <= S_IDLE;
                    r_disp_enable <= 1'b0;
                    r_disp_w_en   <= 1'b0;
                end
            endcase
        end
    end

    assign busy         = w_full;
    assign level        = r_level;
    assign overflow     = r_overflow;
    assign disp_address = 1'b0;
    assign disp_enable  = r_disp_enable;
    assign disp_w_en    = r_disp_w_en;
    assign disp_din     = r_disp_din;

endmodule

// File: tb/tb_display_tx_queue.sv
// Directed bench for display_tx_queue with PACE_CYCLES shortened to 100.
// Strobe times are recorded as the count of rising edges seen when the strobe is high.
// Inputs change on the falling edge; outputs are sampled there too.
module tb_display_tx_queue;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int PACE   = 100;
    localparam int GAP    = 4;

    logic              clk14 = 1'b0;
    logic              rst;
    logic              cpu_we;
    logic [7:0]        cpu_din;
    logic              fast;
    logic              flush;
    logic              busy;
    logic [ADDR_W:0]   level;
    logic              overflow;
    logic              disp_address;
    logic              disp_enable;
    logic              disp_w_en;
    logic [7:0]        disp_din;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int         st_t [$];
    logic [7:0] st_d [$];
    logic [7:0] prev_din = 8'h00;

    display_tx_queue #(
        .DEPTH       (DEPTH),
        .ADDR_W      (ADDR_W),
        .PACE_CYCLES (PACE),
        .GAP_FAST    (GAP),
        .CNT_W       (18)
    ) dut (
        .clk14        (clk14),
        .rst          (rst),
        .cpu_we       (cpu_we),
        .cpu_din      (cpu_din),
        .fast         (fast),
        .flush        (flush),
        .busy         (busy),
        .level        (level),
        .overflow     (overflow),
        .disp_address (disp_address),
        .disp_enable  (disp_enable),
        .disp_w_en    (disp_w_en),
        .disp_din     (disp_din)
    );

    always #5 clk14 = ~clk14;

    always @(posedge clk14) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Strobe monitor: records each strobe and checks w_en tracks enable and data was set up a cycle early.
    always @(negedge clk14) begin
        if (disp_enable === 1'b1 || disp_w_en === 1'b1) begin
            st_t.push_back(cyc);
            st_d.push_back(disp_din);
            chk("strobe_w_en", {31'd0, disp_w_en}, {31'd0, disp_enable});
            chk("din_setup", {24'd0, prev_din}, {24'd0, disp_din});
        end
        prev_din = disp_din;
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clk14);
    endtask

    task automatic wr(input logic [7:0] c);
        cpu_we  = 1'b1;
        cpu_din = c;
        tick(1);
        cpu_we  = 1'b0;
    endtask

    task automatic clrq();
        st_t.delete();
        st_d.delete();
    endtask

    int n0;
    int p0;
    int busy_any;

    initial begin
        rst = 1'b1; cpu_we = 1'b0; cpu_din = 8'h00; fast = 1'b1; flush = 1'b0;
        tick(2);
        // Reset state
        chk("rst_level",    {27'd0, level}, 32'd0);
        chk("rst_busy",     {31'd0, busy}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        chk("rst_enable",   {31'd0, disp_enable}, 32'd0);
        chk("rst_w_en",     {31'd0, disp_w_en}, 32'd0);
        chk("rst_din",      {24'd0, disp_din}, 32'd0);
        chk("rst_address",  {31'd0, disp_address}, 32'd0);
        rst = 1'b0;
        tick(1);

        // Single char, fast: strobe 2 edges after the write edge
        clrq();
        n0 = cyc + 1;
        wr(8'hC1);
        tick(8);
        chk("single_count", st_t.size(), 32'd1);
        if (st_t.size() == 1) begin
            chk("single_time", st_t[0], n0 + 2);
            chk("single_data", {24'd0, st_d[0]}, 32'hC1);
        end
        chk("single_level", {27'd0, level}, 32'd0);

        // Burst of 5, fast: strobes 6 cycles apart, in order
        clrq();
        n0 = cyc + 1;
        for (int i = 0; i < 5; i++) wr(8'hC1 + 8'(i));
        tick(40);
        chk("burst_count", st_t.size(), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < st_t.size()) begin
                chk($sformatf("burst_time%0d", i), st_t[i], n0 + 2 + 6 * i);
                chk($sformatf("burst_data%0d", i), {24'd0, st_d[i]}, 32'hC1 + i);
            end
        end
        chk("burst_level", {27'd0, level}, 32'd0);

        // Paced, 3 chars: strobes 102 cycles apart, busy never rises
        clrq();
        fast = 1'b0;
        n0 = cyc + 1;
        wr(8'hA1); wr(8'hA2); wr(8'hA3);
        busy_any = 0;
        for (int i = 0; i < 320; i++) begin
            if (busy === 1'b1) busy_any = 1;
            tick(1);
        end
        chk("paced_busy", busy_any, 32'd0);
        chk("paced_count", st_t.size(), 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < st_t.size()) begin
                chk($sformatf("paced_time%0d", i), st_t[i], n0 + 2 + 102 * i);
                chk($sformatf("paced_data%0d", i), {24'd0, st_d[i]}, 32'hA1 + i);
            end
        end

        // Flush mid-WAIT with 8 queued; a write on the flush cycle is dropped
        clrq();
        for (int i = 0; i < 9; i++) wr(8'h61 + 8'(i));
        chk("flush_pre_level", {27'd0, level}, 32'd8);
        tick(20);
        flush = 1'b1; cpu_we = 1'b1; cpu_din = 8'h7F;
        tick(1);
        flush = 1'b0; cpu_we = 1'b0;
        chk("flush_level",    {27'd0, level}, 32'd0);
        chk("flush_busy",     {31'd0, busy}, 32'd0);
        chk("flush_overflow", {31'd0, overflow}, 32'd0);
        chk("flush_enable",   {31'd0, disp_enable}, 32'd0);
        tick(250);
        chk("flush_strobes",  st_t.size(), 32'd1);
        chk("flush_level2",   {27'd0, level}, 32'd0);
        chk("flush_din_kept", {24'd0, disp_din}, 32'h61);

        // Fill to full while pacing: busy at the 16th write, overflow on the 17th
        clrq();
        p0 = cyc + 1;
        wr(8'hB0);
        tick(3);
        for (int k = 0; k < 17; k++) begin
            wr(8'h10 + 8'(k));
            if (k < 16) begin
                chk($sformatf("fill_level%0d", k + 1), {27'd0, level}, k + 1);
                chk($sformatf("fill_busy%0d", k + 1), {31'd0, busy}, (k == 15) ? 32'd1 : 32'd0);
                chk($sformatf("fill_ovf%0d", k + 1), {31'd0, overflow}, 32'd0);
            end
        end
        chk("ovf_set",   {31'd0, overflow}, 32'd1);
        chk("ovf_level", {27'd0, level}, 32'd16);
        chk("ovf_busy",  {31'd0, busy}, 32'd1);

        // Push and pop on the same edge at full (pop edge is p0+103)
        while (cyc < p0 + 102) tick(1);
        chk("swap_prelevel", {27'd0, level}, 32'd16);
        wr(8'hD0);
        chk("swap_level", {27'd0, level}, 32'd16);
        chk("swap_busy",  {31'd0, busy}, 32'd1);
        tick(2);
        chk("swap_count", st_t.size(), 32'd2);
        if (st_t.size() == 2) begin
            chk("primer_time", st_t[0], p0 + 2);
            chk("primer_data", {24'd0, st_d[0]}, 32'hB0);
            chk("swap_time",   st_t[1], p0 + 104);
            chk("swap_data",   {24'd0, st_d[1]}, 32'h10);
        end

        // Reset mid-WAIT returns everything to the reset state
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("rst2_level",    {27'd0, level}, 32'd0);
        chk("rst2_overflow", {31'd0, overflow}, 32'd0);
        chk("rst2_din",      {24'd0, disp_din}, 32'd0);
        tick(5);
        chk("rst2_strobes",  st_t.size(), 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
